// File: rtl/apb_slave_regs.sv
// APB3 completer with a DEPTH x 32-bit register file and WAIT_CYCLES wait states per transfer.
// Optional: define APB_SLV_PSLVERR_EN to answer out-of-range accesses with pslverr=1.
module apb_slave_regs #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pwrite_q, pwrite_d;
  logic              in_range_q, in_range_d;
  logic              pready_q, pready_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic              setup;
  logic              addr_ok;
  logic              commit;
  logic [IDX_W-1:0]  paddr_idx;
  logic [DEPTH-1:0]  wr_en;

  assign setup     = psel & ~penable;
  assign addr_ok   = (paddr < DEPTH_A);
  assign paddr_idx = paddr[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pwrite_d   = pwrite_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    prdata_d   = prdata_q;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          pwrite_d   = pwrite;
          idx_d      = paddr_idx;
          in_range_d = addr_ok;
          cnt_d      = 4'd0;
          state_d    = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
          if (!pwrite) begin
            prdata_d = addr_ok ? regs_q[paddr_idx] : '0;
          end
        end
      end
      S_WAIT: begin
        // Requester dropping psel mid-transfer abandons it without side effects.
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable) begin
          if (cnt_q == WAIT_LAST) begin
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        commit  = psel & penable & pwrite_q & in_range_q;
      end
      default: state_d = S_IDLE;
    endcase
    pready_d = (state_d == S_READY);
  end

  // One-hot write strobes; only an in-range captured index can ever assert one.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = commit & (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      pwrite_q   <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pwrite_q   <= pwrite_d;
      in_range_q <= in_range_d;
      idx_q      <= idx_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          regs_q[i] <= pwdata;
        end
      end
    end
  end

  assign prdata = prdata_q;
  assign pready = pready_q;

`ifdef APB_SLV_PSLVERR_EN
  logic pslverr_q, pslverr_d;

  // in_range_d is used so the zero-wait path sees the range just decoded at setup.
  assign pslverr_d = (state_d == S_READY) & ~in_range_d;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pslverr_q <= 1'b0;
    end else begin
      pslverr_q <= pslverr_d;
    end
  end

  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: three instances (0, 1 and 3 wait states) share one APB bus,
// checked against a table of vectors, hand-written corner sequences and a random run vs an array model.
module tb_apb_slave_regs;

  localparam int N = 3;
`ifdef APB_SLV_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        pclk    = 1'b0;
  logic        preset  = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = '0;
  logic [31:0] pwdata  = '0;

  logic [31:0] prdata_w  [N];
  logic        pready_w  [N];
  logic        pslverr_w [N];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [16];
  logic [31:0] last_rd;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [14];

  always #5 pclk = ~pclk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      apb_slave_regs #(
        .DEPTH      (16),
        .ADDR_W     (32),
        .DATA_W     (32),
        .WAIT_CYCLES((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
      ) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata_w[gi]),
        .pready (pready_w[gi]),
        .pslverr(pslverr_w[gi])
      );
    end
  endgenerate

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Full transfer, held until the slowest instance completes; the faster ones
  // return to IDLE and must ignore the lingering access phase.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit exp_err);
    int          lat    [N];
    int          pulses [N];
    logic [31:0] rd     [N];
    logic        er     [N];
    int          cyc;
    for (int k = 0; k < N; k++) begin
      lat[k] = 0; pulses[k] = 0; rd[k] = 'x; er[k] = 1'bx;
    end
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    for (int k = 0; k < N; k++) chk("setup_pready", k, 32'(pready_w[k]), 32'd0);
    cyc = 0;
    do begin
      @(posedge pclk); #1;
      penable = 1'b1;
      cyc++;
      @(negedge pclk);
      for (int k = 0; k < N; k++) begin
        chk("pslverr_only_with_pready", k, 32'(pslverr_w[k] & ~pready_w[k]), 32'd0);
        if (pready_w[k]) begin
          pulses[k]++;
          if (lat[k] == 0) begin
            lat[k] = cyc; rd[k] = prdata_w[k]; er[k] = pslverr_w[k];
          end
        end
      end
    end while (!pready_w[N-1] && cyc < 12);
    for (int k = 0; k < N; k++) begin
      chk("latency", k, 32'(lat[k]), 32'(wait_of(k) + 1));
      chk("pready_pulses", k, 32'(pulses[k]), 32'd1);
      chk("pslverr", k, 32'(er[k]), 32'(exp_err));
      chk("prdata", k, rd[k], exp_rd);
    end
    $display("xfer wr=%0d addr=%0d wdata=%h rdata=%h err=%0d", wr, a, d, rd[1], er[1]);
  endtask

  task automatic model_update(input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (wr) begin
      if (a < 16) mem[a[3:0]] = d;
    end else begin
      last_rd = (a < 16) ? mem[a[3:0]] : 32'd0;
    end
  endtask

  task automatic model_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    if (wr) exp_rd = last_rd;
    else    exp_rd = (a < 16) ? mem[a[3:0]] : 32'd0;
    xfer(wr, a, d, exp_rd, ERR_EN && (a >= 16));
    model_update(wr, a, d);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    last_rd = '0;
  endtask

  initial begin
    model_clear();
    tbl[0]  = '{1'b1, 32'd5,  32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 32'd5,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'd4,  32'h0,        32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 32'd6,  32'h0,        32'h00000000, 1'b0};
    tbl[4]  = '{1'b1, 32'd16, 32'h11111111, 32'h00000000, ERR_EN};
    tbl[5]  = '{1'b0, 32'd16, 32'h0,        32'h00000000, ERR_EN};
    tbl[6]  = '{1'b0, 32'd5,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b0, 32'd0,  32'h0,        32'h00000000, 1'b0};
    tbl[8]  = '{1'b1, 32'd2,  32'h12345678, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b0, 32'd2,  32'h0,        32'h12345678, 1'b0};
    tbl[10] = '{1'b1, 32'd7,  32'hCAFEF00D, 32'h12345678, 1'b0};
    tbl[11] = '{1'b1, 32'd15, 32'h0F0F0F0F, 32'h12345678, 1'b0};
    tbl[12] = '{1'b0, 32'd15, 32'h0,        32'h0F0F0F0F, 1'b0};
    tbl[13] = '{1'b0, 32'd7,  32'h0,        32'hCAFEF00D, 1'b0};

    // Reset state
    repeat (2) @(negedge pclk);
    for (int k = 0; k < N; k++) begin
      chk("reset_pready", k, 32'(pready_w[k]), 32'd0);
      chk("reset_pslverr", k, 32'(pslverr_w[k]), 32'd0);
      chk("reset_prdata", k, prdata_w[k], 32'd0);
    end
    @(posedge pclk); #1;
    preset = 1'b0;

    // Every register reads zero after reset
    for (int i = 0; i < 16; i++) model_xfer(1'b0, 32'(i), 32'd0);

    // Vector table, back-to-back transfers
    for (int i = 0; i < 14; i++) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
      model_update(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
    end

    // Abort: psel dropped while the waiting instances are in WAIT
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd7; pwdata = 32'hA5A5A5A5;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      for (int k = 1; k < N; k++) chk("abort_pready", k, 32'(pready_w[k]), 32'd0);
    end
    model_xfer(1'b0, 32'd7, 32'd0);

    // Access phase without a setup phase is ignored
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'd3; pwdata = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      for (int k = 0; k < N; k++) chk("nosetup_pready", k, 32'(pready_w[k]), 32'd0);
    end
    model_xfer(1'b0, 32'd3, 32'd0);

    // Random traffic against the model, including out-of-range indices
    for (int i = 0; i < 40; i++) begin
      model_xfer(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19)), $urandom);
    end
    model_xfer(1'b1, 32'd9, 32'h5A5AC3C3);

    // Reset asserted mid-transfer clears outputs immediately
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'd9;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("pre_reset_pready", 0, 32'(pready_w[0]), 32'd1);
    preset = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("async_reset_pready", k, 32'(pready_w[k]), 32'd0);
      chk("async_reset_prdata", k, prdata_w[k], 32'd0);
      chk("async_reset_pslverr", k, 32'(pslverr_w[k]), 32'd0);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) model_xfer(1'b0, 32'(i), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
